imm_gen_pipe: RTL and testbench

//  Registered, XLEN-parametrised RV immediate generator with valid/ready handshake on both sides.

---
 rtl/imm_gen_pkg.sv | 38 +++
 rtl/imm_decode.sv | 45 ++++
 rtl/imm_gen_pipe.sv | 145 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the RV immediate generator.
//   imm_fmt_e   : immediate format tag carried with each decoded entry
//   OPC_*       : 7-bit major opcodes recognised by the decoder
//   imm_entry_t : decoded payload {imm (full 64-bit sign-extended), fmt, illegal}
package imm_gen_pkg;

    localparam int unsigned ILEN_W    = 32;
    localparam int unsigned IMM_MAX_W = 64;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned FMT_W     = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;

    // imm is always produced at the widest legal XLEN; narrower builds truncate.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder.
//   inst    : raw 32-bit instruction word
//   entry_c : {64-bit sign-extended imm, format tag, unsupported-opcode flag}
module imm_decode
    import imm_gen_pkg::*;
(
    input  logic [ILEN_W-1:0] inst,
    output imm_entry_t        entry_c
);

    // Sign bit is always inst[31]; each format places its fields under it.
    always_comb begin
        entry_c         = '0;
        entry_c.fmt     = FMT_NONE;
        entry_c.illegal = 1'b0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM_32: begin
                entry_c.imm = {{52{inst[31]}}, inst[31:20]};
                entry_c.fmt = FMT_I;
            end
            OPC_STORE: begin
                entry_c.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
                entry_c.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                entry_c.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0};
                entry_c.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                entry_c.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
                entry_c.fmt = FMT_U;
            end
            OPC_JAL: begin
                entry_c.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0};
                entry_c.fmt = FMT_J;
            end
            default: begin
                entry_c.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with valid/ready on both sides and a
// one-entry skid buffer so downstream stalls never drop an instruction.
// Optional feature macro: IMM_GEN_ILLEGAL_FLAG_EN (registered out_illegal;
// otherwise out_illegal is tied low).
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready registered, = skid empty)
//   in_inst               : raw instruction word
//   out_valid/out_ready   : output handshake
//   out_imm, out_fmt      : sign-extended immediate and format tag
//   out_illegal           : unsupported-opcode flag
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [FMT_W-1:0]  out_fmt,
    output logic              out_illegal
);

    // Elaboration-time parameter checks.
    if (ILEN != ILEN_W) begin : g_bad_ilen
        $error("imm_gen_pipe: ILEN must be 32");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    imm_entry_t dec;

    imm_decode u_decode (
        .inst    (in_inst),
        .entry_c (dec)
    );

    logic [XLEN-1:0] dec_imm;
    assign dec_imm = dec.imm[XLEN-1:0];

    // Upper imm bits are intentionally dropped when XLEN=32.
    logic unused_dec;
    assign unused_dec = ^{dec.imm, dec.illegal};

    logic            skid_valid_q;
    logic [XLEN-1:0] skid_imm_q;
    imm_fmt_e        skid_fmt_q;

    logic            out_valid_d, skid_valid_d, in_ready_d;
    logic [XLEN-1:0] out_imm_d, skid_imm_d;
    imm_fmt_e        out_fmt_d, skid_fmt_d;

    logic in_fire_c, load_out_c;
    assign in_fire_c  = in_valid && in_ready;
    assign load_out_c = !out_valid || out_ready;

    // Next-state: output register refills from skid first, then from input.
    always_comb begin
        out_valid_d  = out_valid;
        out_imm_d    = out_imm;
        out_fmt_d    = imm_fmt_e'(out_fmt);
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        if (load_out_c) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_c) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec.fmt;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire_c) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec.fmt;
        end
        in_ready_d = !skid_valid_d;
    end

    // Pipeline and skid registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            in_ready     <= 1'b1;
        end else begin
            out_valid    <= out_valid_d;
            out_imm      <= out_imm_d;
            out_fmt      <= out_fmt_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            in_ready     <= in_ready_d;
        end
    end

`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    logic skid_ill_q;
    logic out_ill_d, skid_ill_d;

    // Illegal flag follows the same path as imm/fmt.
    always_comb begin
        out_ill_d  = out_illegal;
        skid_ill_d = skid_ill_q;
        if (load_out_c) begin
            if (skid_valid_q) begin
                out_ill_d = skid_ill_q;
            end else if (in_fire_c) begin
                out_ill_d = dec.illegal;
            end
        end else if (in_fire_c) begin
            skid_ill_d = dec.illegal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_illegal <= 1'b0;
            skid_ill_q  <= 1'b0;
        end else begin
            out_illegal <= out_ill_d;
            skid_ill_q  <= skid_ill_d;
        end
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=64 and XLEN=32 instances).
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe #(.XLEN(64), .ILEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(32), .ILEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-decoded vectors.
    localparam int NV = 8;
    logic [31:0] vin   [NV] = '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'h0010006F,
                                32'h800000B7, 32'h00001017, 32'h0000007F, 32'h7FF00013};
    logic [63:0] vexp  [NV] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                                64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0800,
                                64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_1000,
                                64'h0, 64'h0000_0000_0000_07FF};
    logic [31:0] vexp32[NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                32'h80000000, 32'h00001000, 32'h0, 32'h000007FF};
    logic [2:0]  vfmt  [NV] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd0, 3'd1};
    logic        vill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILL_EXP, 1'b0};

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_fmt, out_illegal} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got v/fmt/ill=%b required 00000", {out_valid, out_fmt, out_illegal});
        end
        n_checks++;
        if (out_imm !== 64'h0) begin
            n_fail++; $display("FAIL reset_imm: got %h required 0", out_imm);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, in_ready32, out_valid} !== 3'b110) begin
            n_fail++; $display("FAIL reset_release: got rdy/rdy32/v=%b required 110", {in_ready, in_ready32, out_valid});
        end
    endtask

    task automatic test_decode;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_inst = vin[i]; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, out_fmt, out_illegal} !== {1'b1, vfmt[i], vill[i]}) begin
                n_fail++; $display("FAIL decode64_ctl[%0d]: got v/fmt/ill=%b required %b", i,
                                   {out_valid, out_fmt, out_illegal}, {1'b1, vfmt[i], vill[i]});
            end
            n_checks++;
            if (out_imm !== vexp[i]) begin
                n_fail++; $display("FAIL decode64_imm[%0d]: got %h required %h", i, out_imm, vexp[i]);
            end
            n_checks++;
            if ({out_valid32, out_fmt32, out_illegal32, out_imm32} !== {1'b1, vfmt[i], vill[i], vexp32[i]}) begin
                n_fail++; $display("FAIL decode32[%0d]: got v=%b fmt=%0d ill=%b imm=%h required fmt=%0d ill=%b imm=%h", i,
                                   out_valid32, out_fmt32, out_illegal32, out_imm32, vfmt[i], vill[i], vexp32[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL decode_drain[%0d]: got out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = vin[i];
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, out_fmt, out_imm} !== {1'b1, 1'b1, vfmt[i], vexp[i]}) begin
                n_fail++; $display("FAIL b2b[%0d]: got v=%b rdy=%b fmt=%0d imm=%h required v=1 rdy=1 fmt=%0d imm=%h",
                                   i, out_valid, in_ready, out_fmt, out_imm, vfmt[i], vexp[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_stall_stream;
        int sent = 0;
        int rcv  = 0;
        logic in_fire, out_fire;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            in_valid  = (sent < 4);
            in_inst   = (sent < 4) ? vin[sent] : 32'h0;
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                n_checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    n_fail++; $display("FAIL stall_full: got in_ready=%b accepted=%0d required 0 and 2", in_ready, sent);
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                n_checks++;
                if ({out_fmt, out_imm} !== {vfmt[rcv], vexp[rcv]}) begin
                    n_fail++; $display("FAIL stream_order[%0d]: got fmt=%0d imm=%h required fmt=%0d imm=%h",
                                       rcv, out_fmt, out_imm, vfmt[rcv], vexp[rcv]);
                end
                rcv++;
            end
            @(posedge clk); #1;
            if (in_fire) sent++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rcv != 4) begin
            n_fail++; $display("FAIL stream_count: got %0d outputs required 4 (timeout)", rcv);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_dup: got out_valid=%b after drain required 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = vin[0];
        @(posedge clk); #1;
        in_inst = vin[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL midrst_fill: got v/rdy=%b required 10", {out_valid, in_ready});
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL midrst_async: got v/rdy=%b required 01", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++; $display("FAIL midrst_after[%0d]: got v/rdy=%b required 01", i, {out_valid, in_ready});
            end
        end
        in_valid = 1'b1; in_inst = vin[3];
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_fmt, out_imm} !== {1'b1, vfmt[3], vexp[3]}) begin
            n_fail++; $display("FAIL midrst_resume: got v=%b fmt=%0d imm=%h required v=1 fmt=%0d imm=%h",
                               out_valid, out_fmt, out_imm, vfmt[3], vexp[3]);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_stall_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
